// File: rtl/br_resolve_queue.sv
// Resolved-branch queue: buffers up to two branch results per cycle and issues one per cycle
// to the mask controller, squashing dependents of a mispredicted branch as it issues.
`ifndef BR_MASK_W
`define BR_MASK_W 5
`endif
`ifndef BR_STATE_W
`define BR_STATE_W 2
`endif
`ifndef BR_NONE
`define BR_NONE 2'd0
`endif
`ifndef BR_PR_CORRECT
`define BR_PR_CORRECT 2'd1
`endif
`ifndef BR_PR_WRONG
`define BR_PR_WRONG 2'd2
`endif

module br_resolve_queue #(
    parameter int BR_MASK_W = `BR_MASK_W,
    parameter int QD        = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               ex_br_valid_i,
    input  logic [1:0]               ex_br_wrong_i,
    input  logic [2*BR_MASK_W-1:0]   ex_br_mask_i,
    output logic                     ex_ready_o,
    output logic [`BR_STATE_W-1:0]   br_state_o,
    output logic [BR_MASK_W-1:0]     br_dep_mask_o,
    output logic                     br_recover_o,
    output logic [$clog2(QD):0]      count_o
);
    localparam int PTR_W = $clog2(QD);
    localparam int CNT_W = PTR_W + 1;

    logic [QD-1:0]        q_valid;
    logic [QD-1:0]        q_wrong;
    logic [BR_MASK_W-1:0] q_mask [QD];
    logic [PTR_W-1:0]     head;
    logic [CNT_W-1:0]     count;

    logic                 head_valid;
    logic                 head_wrong;
    logic [BR_MASK_W-1:0] head_mask;
    logic [BR_MASK_W-1:0] squash_w;
    logic [BR_MASK_W-1:0] m0;
    logic [BR_MASK_W-1:0] m1;
    logic [BR_MASK_W-1:0] own0;
    logic                 take0;
    logic                 take1;
    logic [PTR_W-1:0]     head_next;
    logic [PTR_W-1:0]     idx;
    logic [PTR_W-1:0]     widx;
    logic [CNT_W-1:0]     n_keep;
    logic [QD-1:0]        nx_valid;
    logic [QD-1:0]        nx_wrong;
    logic [BR_MASK_W-1:0] nx_mask [QD];

    assign head_valid = q_valid[head];
    assign head_wrong = q_wrong[head];
    assign head_mask  = q_mask[head];

    // Own branch bit is the lowest zero of the mask: ~m & (m + 1) isolates it.
    assign squash_w = (head_valid && head_wrong) ? (~head_mask & (head_mask + BR_MASK_W'(1))) : '0;

    assign m0   = ex_br_mask_i[0 +: BR_MASK_W];
    assign m1   = ex_br_mask_i[BR_MASK_W +: BR_MASK_W];
    assign own0 = ~m0 & (m0 + BR_MASK_W'(1));

    assign ex_ready_o = (CNT_W'(QD) - count) >= CNT_W'(2);

    assign take0 = ex_ready_o && ex_br_valid_i[0] && ((m0 & squash_w) == '0);
    assign take1 = ex_ready_o && ex_br_valid_i[1] && ((m1 & squash_w) == '0) &&
                   !(ex_br_valid_i[0] && ex_br_wrong_i[0] && ((m1 & own0) != '0));

    assign head_next = head + PTR_W'(head_valid);

    // Rebuild the whole ring each cycle: survivors behind the popped head, then new arrivals,
    // packed contiguously from the next head position.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch can be inferred;
        // n_keep and widx are running values, hence blocking assignments.
        nx_valid = '0;
        nx_wrong = '0;
        for (int j = 0; j < QD; j++) nx_mask[j] = '0;
        n_keep = '0;
        idx    = '0;
        widx   = '0;
        for (int k = 1; k < QD; k++) begin
            idx = head + PTR_W'(k);
            if (q_valid[idx] && ((q_mask[idx] & squash_w) == '0)) begin
                widx           = head_next + n_keep[PTR_W-1:0];
                nx_valid[widx] = 1'b1;
                nx_wrong[widx] = q_wrong[idx];
                nx_mask[widx]  = q_mask[idx];
                n_keep         = n_keep + CNT_W'(1);
            end
        end
        if (take0) begin
            widx           = head_next + n_keep[PTR_W-1:0];
            nx_valid[widx] = 1'b1;
            nx_wrong[widx] = ex_br_wrong_i[0];
            nx_mask[widx]  = m0;
            n_keep         = n_keep + CNT_W'(1);
        end
        if (take1) begin
            widx           = head_next + n_keep[PTR_W-1:0];
            nx_valid[widx] = 1'b1;
            nx_wrong[widx] = ex_br_wrong_i[1];
            nx_mask[widx]  = m1;
            n_keep         = n_keep + CNT_W'(1);
        end
    end

    // NOTE: only valid bits and pointers are reset; the payload of an invalid slot is never observed.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_valid <= '0;
            head    <= '0;
            count   <= '0;
        end else begin
            q_valid <= nx_valid;
            head    <= head_next;
            count   <= n_keep;
        end
    end

    always_ff @(posedge clk) begin
        q_wrong <= nx_wrong;
        for (int j = 0; j < QD; j++) q_mask[j] <= nx_mask[j];
    end

    assign br_state_o    = !head_valid ? `BR_NONE : (head_wrong ? `BR_PR_WRONG : `BR_PR_CORRECT);
    assign br_dep_mask_o = head_valid ? head_mask : '0;
    assign br_recover_o  = head_valid && head_wrong;
    assign count_o       = count;

endmodule

// File: doc/br_resolve_queue.md
Name: br_resolve_queue

Overview:
- Buffers resolved-branch results coming from the branch execution units.
- Issues at most one resolution per cycle to the branch mask controller on the br_state / br_dep_mask interface.
- On a mispredict issue, drops every queued or same-cycle incoming result that depends on the mispredicted branch.
- Sits between the execute-stage branch units and the mask controller / ROB.

Parameters:
- BR_MASK_W, `BR_MASK_W, width of a branch dependency mask.
- QD, 4, queue depth in entries (power of two, ≥2).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- ex_br_valid_i  input  2  per-port resolved-branch valid; port 0 is older than port 1 in the same cycle
- ex_br_wrong_i  input  2  per-port mispredict flag; 1 = wrong, 0 = correct
- ex_br_mask_i  input  2*BR_MASK_W  per-port dependency mask captured at dispatch; port p occupies bits [p*BR_MASK_W +: BR_MASK_W]
- ex_ready_o  output  1  at least 2 free entries; execute may present results this cycle
- br_state_o  output  `BR_STATE_W  `BR_PR_WRONG / `BR_PR_CORRECT / `BR_NONE (idle)
- br_dep_mask_o  output  BR_MASK_W  dependency mask of the issued branch
- br_recover_o  output  1  high exactly when br_state_o == `BR_PR_WRONG; dispatch must stall this cycle
- count_o  output  $clog2(QD)+1  current occupancy

Behaviour:
- Reset (synchronous, active-high):
  - queue empty, head/tail pointers 0, count_o = 0
  - br_state_o = `BR_NONE, br_dep_mask_o = 0, br_recover_o = 0, ex_ready_o = 1
  - reset in mid-operation discards all entries.
- Entry fields: valid, wrong, mask[BR_MASK_W].
- Own branch bit of an entry = one-hot of the lowest-index 0 in its mask. An all-ones mask cannot occur; the bench flags it as an error.
- Issue:
  - head entry is presented combinationally on br_state_o / br_dep_mask_o
  - the controller always accepts, so the head pops every cycle it is valid
  - with no valid head, br_state_o = `BR_NONE.
- Latency: a result enqueued at edge N is eligible to issue in the cycle after edge N. No same-cycle bypass.
- Enqueue order: port 0 before port 1. Both are written in one cycle when both are valid and not squashed.
- ex_ready_o = (QD - count) ≥ 2, computed from registered count. Results presented while ex_ready_o = 0 are a protocol violation and are ignored (not enqueued).
- Squash on mispredict issue. When the head issues as wrong with own bit W, in the same cycle:
  - every other queued entry with mask & W ≠ 0 is invalidated
  - every incoming result with mask & W ≠ 0 is dropped
  - invalidated entries are compacted out before the next cycle, so the queue stays contiguous and count reflects survivors.
- Same-cycle input squash: if port 0 is wrong with own bit W0 and port 1's mask & W0 ≠ 0, port 1 is dropped.
- An incoming wrong result does not squash already-queued entries. Those are squashed when it reaches the head.
- Correct resolutions never modify stored masks. Bits of not-yet-issued older branches stay set, so each entry's lowest-zero own bit remains valid.
- Pointer wrap: modulo QD. Full when count == QD. Simultaneous pop and push of 2 are allowed when ex_ready_o = 1.
- count_next = count - pop - squashed + enqueued; it never exceeds QD.

Test Plan:
- Single correct: after reset, port0 valid, wrong = 0, mask = 5'b00011 → next cycle br_state_o = `BR_PR_CORRECT, br_dep_mask_o = 00011, br_recover_o = 0; following cycle `BR_NONE, count_o = 0.
- Dual enqueue ordering: both ports correct, masks 00001 / 00011 → port 0 result issues in cycle +1, port 1 in cycle +2; count_o goes 2 → 1 → 0.
- Mispredict squash in queue:
  - enqueue wrong mask 00000 (W = 00001), then correct masks 00001 and 00011 on following cycles while the head is stalled by earlier entries
  - when the wrong entry issues: br_recover_o = 1, both dependents vanish, count_o drops by 3, next cycle `BR_NONE.
- Same-cycle squash: port0 wrong mask 00001 (W = 00010), port1 correct mask 00011 → only port 0 enqueued; count_o = 1.
- Backpressure: hold 2-port inputs with QD = 4 → ex_ready_o falls when count_o ≥ 3; inputs asserted while not ready are not stored; ex_ready_o returns after pops.
- Reset mid-operation: queue at 3 entries, assert rst one cycle → count_o = 0, br_state_o = `BR_NONE, ex_ready_o = 1 on the following cycle.
